// File: rtl/encoder_param_ctrl_if.sv
// Encoder pin bundle in, selected channel / mode / channel values / step pulses out.
interface encoder_param_ctrl_if;
  logic [3:0]  d_encoder;
  logic [1:0]  sel;
  logic        edit_mode;
  logic [63:0] cntr_bus;
  logic        step_cw;
  logic        step_ccw;

  modport master (
    output d_encoder,
    input  sel, edit_mode, cntr_bus, step_cw, step_ccw
  );

  modport slave (
    input  d_encoder,
    output sel, edit_mode, cntr_bus, step_cw, step_ccw
  );
endinterface

// File: rtl/encoder_param_ctrl.sv
// Rotary-encoder parameter editor: the encoder selects one of four channels or edits its
// value, the button toggles SELECT/EDIT, and EDIT falls back to SELECT after idling.
module encoder_param_ctrl #(
  parameter int unsigned MAX_VAL      = 999,
  parameter int unsigned DEBOUNCE_CYC = 200,
  parameter int unsigned TIMEOUT_CYC  = 50000
) (
  input  logic                clk_10k,
  input  logic                rst,
  encoder_param_ctrl_if.slave enc
);
  localparam int unsigned N_CH  = 4;
  localparam int unsigned VAL_W = 16;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {
    ST_SELECT = 1'b0,
    ST_EDIT   = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  q_ab;
  logic [3:0]                  hist;
  logic                        cw_c, ccw_c;
  logic                        btn_s1, btn_s2, btn_db, press_q;
  logic [DB_W-1:0]             db_cnt;
  logic [TO_W-1:0]             tcnt_q, tcnt_d;
  logic [1:0]                  sel_q, sel_d;
  logic [N_CH-1:0][VAL_W-1:0]  chan_q, chan_d;
  logic [VAL_W-1:0]            cur_val;
  logic                        step_cw_q, step_cw_d;
  logic                        step_ccw_q, step_ccw_d;
  logic                        unused_pin;

  assign unused_pin = enc.d_encoder[3];

  // Quadrature sample plus a two-deep history of distinct A/B states
  always_ff @(posedge clk_10k or negedge rst) begin
    if (!rst) begin
      q_ab <= 2'b00;
      hist <= 4'b1111;
    end else begin
      q_ab <= enc.d_encoder[1:0];
      if (q_ab != hist[1:0]) begin
        hist <= {hist[1:0], q_ab};
      end
    end
  end

  // A detent completes when 11 is reached via 00->10 (CW) or 00->01 (CCW)
  assign cw_c  = (q_ab == 2'b11) && (hist == 4'b0010);
  assign ccw_c = (q_ab == 2'b11) && (hist == 4'b0001);

  // Button synchroniser, debouncer and single-cycle press event on 1->0
  always_ff @(posedge clk_10k or negedge rst) begin
    if (!rst) begin
      btn_s1  <= 1'b1;
      btn_s2  <= 1'b1;
      btn_db  <= 1'b1;
      db_cnt  <= '0;
      press_q <= 1'b0;
    end else begin
      btn_s1  <= enc.d_encoder[2];
      btn_s2  <= btn_s1;
      press_q <= 1'b0;
      if (btn_s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
        btn_db  <= btn_s2;
        db_cnt  <= '0;
        press_q <= ~btn_s2;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_10k or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_SELECT;
      sel_q      <= '0;
      chan_q     <= '0;
      tcnt_q     <= '0;
      step_cw_q  <= 1'b0;
      step_ccw_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      chan_q     <= chan_d;
      tcnt_q     <= tcnt_d;
      step_cw_q  <= step_cw_d;
      step_ccw_q <= step_ccw_d;
    end
  end

  // Next state: a press always wins over a detent that lands in the same cycle
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    chan_d     = chan_q;
    tcnt_d     = tcnt_q;
    step_cw_d  = 1'b0;
    step_ccw_d = 1'b0;
    cur_val    = chan_q[sel_q];

    unique case (state_q)
      ST_SELECT: begin
        tcnt_d = '0;
        if (press_q) begin
          state_d = ST_EDIT;
        end else if (cw_c) begin
          sel_d     = sel_q + 2'd1;
          step_cw_d = 1'b1;
        end else if (ccw_c) begin
          sel_d      = sel_q - 2'd1;
          step_ccw_d = 1'b1;
        end
      end

      ST_EDIT: begin
        if (press_q) begin
          state_d = ST_SELECT;
          tcnt_d  = '0;
        end else if (cw_c) begin
          chan_d[sel_q] = (cur_val == VAL_W'(MAX_VAL)) ? '0 : cur_val + VAL_W'(1);
          tcnt_d        = '0;
          step_cw_d     = 1'b1;
        end else if (ccw_c) begin
          chan_d[sel_q] = (cur_val == '0) ? VAL_W'(MAX_VAL) : cur_val - VAL_W'(1);
          tcnt_d        = '0;
          step_ccw_d    = 1'b1;
        end else if (tcnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          state_d = ST_SELECT;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end

      default: begin
        state_d = ST_SELECT;
      end
    endcase
  end

  assign enc.sel       = sel_q;
  assign enc.edit_mode = (state_q == ST_EDIT);
  assign enc.cntr_bus  = chan_q;
  assign enc.step_cw   = step_cw_q;
  assign enc.step_ccw  = step_ccw_q;

endmodule

// File: tb/tb_encoder_param_ctrl.sv
// Bench for encoder_param_ctrl: directed scenarios plus random encoder/button traffic,
// checked every cycle against a behavioural model of the editor.
module tb_encoder_param_ctrl;
  localparam int unsigned MAX_VAL      = 999;
  localparam int unsigned DEBOUNCE_CYC = 200;
  localparam int unsigned TB_TIMEOUT   = 5000;

  logic clk_10k;
  logic rst;
  encoder_param_ctrl_if bus ();

  encoder_param_ctrl #(
    .MAX_VAL      (MAX_VAL),
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .TIMEOUT_CYC  (TB_TIMEOUT)
  ) dut (
    .clk_10k (clk_10k),
    .rst     (rst),
    .enc     (bus)
  );

  initial clk_10k = 1'b0;
  always #5 clk_10k = ~clk_10k;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: distinct-state trail for the encoder, time stamps for debounce/timeout
  int     m_q, m_sync0, m_sync1, m_db, m_sel;
  bit     mm_active, m_press, m_mode, m_scw, m_sccw;
  int     m_chan [4];
  int     trail [$];
  longint cyc = 0, last_act, mm_start;

  function automatic void model_reset();
    m_q = 0;
    trail = '{3, 3};
    m_sync0 = 1;
    m_sync1 = 1;
    m_db = 1;
    mm_active = 0;
    mm_start = 0;
    m_press = 0;
    m_mode = 0;
    m_sel = 0;
    foreach (m_chan[i]) m_chan[i] = 0;
    m_scw = 0;
    m_sccw = 0;
    last_act = 0;
  endfunction

  function automatic void model_step(input logic [3:0] din);
    bit det_cw, det_ccw, nxt_press;
    cyc++;
    det_cw  = (m_q == 3) && (trail[$-1] == 0) && (trail[$] == 2);
    det_ccw = (m_q == 3) && (trail[$-1] == 0) && (trail[$] == 1);
    m_scw  = 0;
    m_sccw = 0;
    if (m_press) begin
      m_mode   = !m_mode;
      last_act = cyc;
    end else if (det_cw || det_ccw) begin
      if (!m_mode) begin
        m_sel = (m_sel + (det_cw ? 1 : 3)) % 4;
      end else begin
        m_chan[m_sel] = (m_chan[m_sel] + (det_cw ? 1 : int'(MAX_VAL))) % (int'(MAX_VAL) + 1);
        last_act = cyc;
      end
      m_scw  = det_cw;
      m_sccw = det_ccw;
    end else if (m_mode && (cyc - last_act == longint'(TB_TIMEOUT))) begin
      m_mode = 0;
    end

    nxt_press = 0;
    if (m_sync1 != m_db) begin
      if (!mm_active) begin
        mm_active = 1;
        mm_start  = cyc;
      end
      if (cyc - mm_start + 1 == longint'(DEBOUNCE_CYC)) begin
        m_db      = m_sync1;
        mm_active = 0;
        nxt_press = (m_db == 0);
      end
    end else begin
      mm_active = 0;
    end
    m_press = nxt_press;
    m_sync1 = m_sync0;
    m_sync0 = int'(din[2]);
    if (m_q != trail[$]) begin
      trail.push_back(m_q);
      void'(trail.pop_front());
    end
    m_q = int'(din[1:0]);
  endfunction

  always @(posedge clk_10k or negedge rst) begin
    if (!rst) model_reset();
    else      model_step(bus.d_encoder);
  end

  // Per-cycle compare plus pulse/edge bookkeeping for the directed checks
  bit          cmp_en = 0;
  bit          prev_edit = 0;
  int          ncyc = 0, cw_cnt = 0, ccw_cnt = 0;
  int          last_cw_ncyc = 0, fall_ncyc = 0;
  logic [63:0] exp_bus;

  always @(negedge clk_10k) begin
    ncyc++;
    if (bus.step_cw) begin
      cw_cnt++;
      last_cw_ncyc = ncyc;
    end
    if (bus.step_ccw) ccw_cnt++;
    if (prev_edit && !bus.edit_mode) fall_ncyc = ncyc;
    prev_edit = bus.edit_mode;
    if (cmp_en) begin
      for (int i = 0; i < 4; i++) exp_bus[16*i +: 16] = 16'(m_chan[i]);
      check("cyc_sel",       64'(bus.sel),       64'(m_sel));
      check("cyc_edit_mode", 64'(bus.edit_mode), 64'(m_mode));
      check("cyc_cntr_bus",  bus.cntr_bus,       exp_bus);
      check("cyc_step_cw",   64'(bus.step_cw),   64'(m_scw));
      check("cyc_step_ccw",  64'(bus.step_ccw),  64'(m_sccw));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_10k);
  endtask

  task automatic detent(input bit cw, input int ph);
    bus.d_encoder[1:0] = 2'b00;
    repeat (ph) @(negedge clk_10k);
    bus.d_encoder[1:0] = cw ? 2'b10 : 2'b01;
    repeat (ph) @(negedge clk_10k);
    bus.d_encoder[1:0] = 2'b11;
    repeat (ph + 2) @(negedge clk_10k);
  endtask

  task automatic press_btn(input int bounce, input int hold);
    for (int i = 0; i < bounce; i++) begin
      bus.d_encoder[2] = i[0];
      @(negedge clk_10k);
    end
    bus.d_encoder[2] = 1'b0;
    repeat (hold) @(negedge clk_10k);
    bus.d_encoder[2] = 1'b1;
    repeat (215) @(negedge clk_10k);
  endtask

  task automatic wait_edit(input logic val, input int budget, input string name);
    int n;
    n = 0;
    while (bus.edit_mode !== val && n < budget) begin
      @(negedge clk_10k);
      n++;
    end
    check(name, 64'(bus.edit_mode), 64'(val));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  int cw_before, kind, n_ops;

  initial begin
    rst = 1'b0;
    bus.d_encoder = 4'b0111;
    repeat (3) @(negedge clk_10k);
    rst = 1'b1;
    cmp_en = 1'b1;

    // Reset and idle
    idle(100);
    #1;
    check("reset_sel",   64'(bus.sel), 64'd0);
    check("reset_edit",  64'(bus.edit_mode), 64'd0);
    check("reset_bus",   bus.cntr_bus, 64'd0);
    check("reset_steps", 64'(cw_cnt + ccw_cnt), 64'd0);

    // SELECT: five CW then one CCW
    detent(1'b1, 20); #1; check("sel_cw1", 64'(bus.sel), 64'd1);
    detent(1'b1, 20); #1; check("sel_cw2", 64'(bus.sel), 64'd2);
    detent(1'b1, 20); #1; check("sel_cw3", 64'(bus.sel), 64'd3);
    detent(1'b1, 20); #1; check("sel_cw4_wrap", 64'(bus.sel), 64'd0);
    detent(1'b1, 20); #1; check("sel_cw5", 64'(bus.sel), 64'd1);
    check("cw_pulse_count", 64'(cw_cnt), 64'd5);
    detent(1'b0, 20); #1; check("sel_ccw", 64'(bus.sel), 64'd0);
    check("ccw_pulse_count", 64'(ccw_cnt), 64'd1);

    // Bouncy press into EDIT, edit channel 0 across the lower wrap
    press_btn(5, 300); #1;
    check("press_to_edit", 64'(bus.edit_mode), 64'd1);
    detent(1'b0, 20); #1; check("ch0_ccw_wrap", 64'(bus.cntr_bus[15:0]), 64'd999);
    detent(1'b1, 20); #1; check("ch0_cw_wrap", 64'(bus.cntr_bus[15:0]), 64'd0);
    detent(1'b1, 20);
    detent(1'b1, 20); #1;
    check("ch0_two_cw", 64'(bus.cntr_bus[15:0]), 64'd2);
    check("others_hold", 64'(bus.cntr_bus[63:16]), 64'd0);

    // Select channel 2 and run it up through the upper wrap
    press_btn(0, 250); #1;
    check("press_to_select", 64'(bus.edit_mode), 64'd0);
    detent(1'b1, 3);
    detent(1'b1, 3); #1;
    check("sel_ch2", 64'(bus.sel), 64'd2);
    press_btn(2, 250);
    repeat (998) detent(1'b1, 2);
    #1; check("ch2_998", 64'(bus.cntr_bus[47:32]), 64'd998);
    detent(1'b1, 2); #1; check("ch2_999", 64'(bus.cntr_bus[47:32]), 64'd999);
    detent(1'b1, 2); #1; check("ch2_wrap0", 64'(bus.cntr_bus[47:32]), 64'd0);
    check("ch0_kept", 64'(bus.cntr_bus[15:0]), 64'd2);

    // Timeout, with a late detent restarting the idle timer
    idle(TB_TIMEOUT - 20); #1;
    check("edit_before_timeout", 64'(bus.edit_mode), 64'd1);
    detent(1'b1, 2);
    idle(TB_TIMEOUT - 20); #1;
    check("edit_after_restart", 64'(bus.edit_mode), 64'd1);
    wait_edit(1'b0, 60, "timeout_exit");
    @(negedge clk_10k); #1;
    check("timeout_edges", 64'(fall_ncyc - last_cw_ncyc), 64'(TB_TIMEOUT));
    check("timeout_keeps_value", 64'(bus.cntr_bus[47:32]), 64'd1);

    // Debounced press landing on the same cycle as a CW detect
    cw_before = cw_cnt;
    bus.d_encoder[2] = 1'b0;
    for (int k = 1; k <= 215; k++) begin
      @(negedge clk_10k);
      if (k == 190) bus.d_encoder[1:0] = 2'b00;
      if (k == 195) bus.d_encoder[1:0] = 2'b10;
      if (k == 201) bus.d_encoder[1:0] = 2'b11;
    end
    #1;
    check("coinc_mode", 64'(bus.edit_mode), 64'd1);
    check("coinc_sel", 64'(bus.sel), 64'd2);
    check("coinc_no_pulse", 64'(cw_cnt), 64'(cw_before));
    bus.d_encoder[2] = 1'b1;
    idle(215);

    // Asynchronous reset in the middle of EDIT
    @(posedge clk_10k);
    #2 rst = 1'b0;
    #1;
    check("arst_sel",  64'(bus.sel), 64'd0);
    check("arst_edit", 64'(bus.edit_mode), 64'd0);
    check("arst_bus",  bus.cntr_bus, 64'd0);
    check("arst_step", 64'({bus.step_cw, bus.step_ccw}), 64'd0);
    idle(3);
    rst = 1'b1;
    idle(10);

    // Random encoder, glitch and button traffic
    n_ops = 120;
    for (int op = 0; op < n_ops; op++) begin
      if (op == 60) begin
        #3 rst = 1'b0;
        @(negedge clk_10k);
        rst = 1'b1;
      end
      kind = int'($urandom_range(0, 9));
      case (kind)
        0, 1, 2: detent(1'b1, int'($urandom_range(1, 4)));
        3, 4, 5: detent(1'b0, int'($urandom_range(1, 4)));
        6: begin
          repeat ($urandom_range(1, 8)) begin
            bus.d_encoder[1:0] = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 3)) @(negedge clk_10k);
          end
          bus.d_encoder[1:0] = 2'b11;
          idle(3);
        end
        7: press_btn(int'($urandom_range(0, 6)), int'($urandom_range(150, 400)));
        8: begin
          bus.d_encoder[2] = 1'b0;
          repeat (40) detent(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
          bus.d_encoder[2] = 1'b1;
          idle(215);
        end
        default: begin
          if ($urandom_range(0, 3) == 0) idle(int'(TB_TIMEOUT) + 50);
          else                           idle(int'($urandom_range(1, 30)));
        end
      endcase
    end
    idle(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
